// File: rtl/lzw_dict_arbiter_pkg.sv
// Shared constants and FSM state encoding for the LZW dictionary arbiter.
package lzw_dict_arbiter_pkg;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int NUM_REQ        = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_CAPTURE,
    ST_RESP
  } state_e;
endpackage

// File: rtl/lzw_dict_arbiter_if.sv
// Requester/response bundle shared by the two dictionary clients and the arbiter.
interface lzw_dict_arbiter_if #(
  parameter int ADDR_WIDTH = lzw_dict_arbiter_pkg::ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = lzw_dict_arbiter_pkg::DATA_WIDTH_DEF
) ();
  import lzw_dict_arbiter_pkg::*;

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 req_we;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [DATA_WIDTH-1:0]              rsp_data;
  logic [ADDR_WIDTH-1:0]              rsp_map;
  logic                               rsp_ok;
  logic                               dict_full;

  modport master (
    output req_valid, req_we, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data, rsp_map, rsp_ok, dict_full
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_data,
    output req_ready, rsp_valid, rsp_data, rsp_map, rsp_ok, dict_full
  );
endinterface

// File: rtl/lzw_dict_arbiter_rr.sv
// Two-way round-robin grant; the priority pointer flips away from whoever was last accepted.
module lzw_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);
  logic prio_q, prio_d;

  always_comb begin
    grant_o = 2'b00;
    if (req_i[prio_q]) begin
      grant_o[prio_q] = 1'b1;
    end else if (req_i[~prio_q]) begin
      grant_o[~prio_q] = 1'b1;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (accept_i) begin
      prio_d = ~grant_o[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
endmodule

// File: rtl/lzw_dict_arbiter.sv
// Shares one LZW dictionary RAM between two requesters; one lookup/insert every four cycles.
module lzw_dict_arbiter
  import lzw_dict_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lzw_dict_arbiter_if.slave     req_if,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic                  ram_valid,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic [ADDR_WIDTH-1:0] ram_map_out,
  input  logic [ADDR_WIDTH-1:0] ram_counter_out
);
  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    grant;
  logic                  accept;
  logic                  id_q, we_q, blocked_q;
  logic [ADDR_WIDTH-1:0] addr_q, snap_q, rsp_map_q;
  logic [DATA_WIDTH-1:0] data_q, rsp_data_q;
  logic                  rsp_ok_q;

  lzw_rr_arbiter u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_if.req_valid & {NUM_REQ{state_q == ST_IDLE}}),
    .accept_i (accept),
    .grant_o  (grant)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_if.req_ready[gi] = (state_q == ST_IDLE) && grant[gi];
      assign req_if.rsp_valid[gi] = (state_q == ST_RESP) && (id_q == 1'(gi));
    end
  endgenerate

  assign accept           = |(req_if.req_valid & req_if.req_ready);
  assign req_if.rsp_data  = rsp_data_q;
  assign req_if.rsp_map   = rsp_map_q;
  assign req_if.rsp_ok    = rsp_ok_q;
  assign req_if.dict_full = (ram_counter_out == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = ST_ACCESS;
      ST_ACCESS:  state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // An insert into a full dictionary never touches the RAM.
  always_comb begin
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = addr_q;
    ram_data_in = data_q;
    if (state_q == ST_ACCESS) begin
      ram_cs = ~blocked_q;
      ram_we = we_q & ~blocked_q;
    end else if (state_q == ST_CAPTURE) begin
      ram_cs = ~we_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      blocked_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      snap_q     <= '0;
      rsp_data_q <= '0;
      rsp_map_q  <= '0;
      rsp_ok_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q      <= grant[1];
        we_q      <= req_if.req_we[grant[1]];
        blocked_q <= req_if.req_we[grant[1]] & req_if.dict_full;
        addr_q    <= req_if.req_addr[grant[1]];
        data_q    <= req_if.req_data[grant[1]];
      end
      if (state_q == ST_ACCESS) begin
        snap_q <= ram_counter_out;
      end
      // An insert took effect only if the RAM advanced its code counter by one.
      if (state_q == ST_CAPTURE) begin
        if (!we_q) begin
          rsp_data_q <= ram_data_out;
          rsp_map_q  <= ram_map_out;
          rsp_ok_q   <= ram_valid;
        end else if (!blocked_q && (ram_counter_out == ADDR_WIDTH'(snap_q + 1'b1))) begin
          rsp_map_q  <= snap_q;
          rsp_ok_q   <= 1'b1;
        end else begin
          rsp_map_q  <= '0;
          rsp_ok_q   <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_lzw_dict_arbiter.sv
// Directed bench for lzw_dict_arbiter with a behavioural dictionary RAM model.
module tb_lzw_dict_arbiter;
  localparam int AW = 12;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lzw_dict_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

  logic          ram_cs, ram_we, ram_valid;
  logic [AW-1:0] ram_addr, ram_map_out, ram_counter_out;
  logic [DW-1:0] ram_data_in, ram_data_out;

  lzw_dict_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_if          (ifc),
    .ram_cs          (ram_cs),
    .ram_we          (ram_we),
    .ram_addr        (ram_addr),
    .ram_data_in     (ram_data_in),
    .ram_valid       (ram_valid),
    .ram_data_out    (ram_data_out),
    .ram_map_out     (ram_map_out),
    .ram_counter_out (ram_counter_out)
  );

  // Dictionary RAM model: codes 0..255 preloaded as literals, inserts take the next code.
  logic          mem_v [4096];
  logic [DW-1:0] mem_d [4096];
  logic [AW-1:0] mem_m [4096];
  logic [AW-1:0] cnt;
  bit            preloaded = 1'b0;
  logic          load_cnt = 1'b0;
  logic [AW-1:0] load_val = '0;

  assign ram_counter_out = cnt;

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 4096; i++) begin
        mem_v[i] <= (i < 256);
        mem_d[i] <= DW'(i);
        mem_m[i] <= AW'(i);
      end
      cnt          <= AW'(256);
      ram_valid    <= 1'b0;
      ram_data_out <= '0;
      ram_map_out  <= '0;
      preloaded    <= 1'b1;
    end else if (load_cnt) begin
      cnt <= load_val;
    end else if (ram_cs) begin
      if (ram_we) begin
        if (!mem_v[ram_addr]) begin
          mem_v[ram_addr] <= 1'b1;
          mem_d[ram_addr] <= ram_data_in;
          mem_m[ram_addr] <= cnt;
          cnt             <= cnt + 1'b1;
        end
      end else begin
        ram_valid    <= mem_v[ram_addr];
        ram_data_out <= mem_d[ram_addr];
        ram_map_out  <= mem_m[ram_addr];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int lat;
  int cs_cnt;

  // Issue one request, wait for its grant and response; records latency and RAM selects.
  task automatic run_op(input int id, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data);
    int wait_c;
    wait_c = 0;
    @(negedge clk);
    ifc.req_valid[id] = 1'b1;
    ifc.req_we[id]    = we;
    ifc.req_addr[id]  = addr;
    ifc.req_data[id]  = data;
    #1;
    while (!ifc.req_ready[id] && wait_c < 20) begin
      @(negedge clk);
      #1;
      wait_c++;
    end
    check_eq($sformatf("grant%0d", id), 64'(ifc.req_ready[id]), 64'd1);
    @(negedge clk);
    ifc.req_valid[id] = 1'b0;
    lat    = 1;
    cs_cnt = int'(ram_cs);
    while (!ifc.rsp_valid[id] && lat < 10) begin
      @(negedge clk);
      lat++;
      cs_cnt += int'(ram_cs);
    end
    check_eq("latency", 64'(lat), 64'd3);
    @(negedge clk);
    check_eq("rsp_pulse", 64'(ifc.rsp_valid), 64'd0);
    $display("[TB] req%0d %s addr=0x%03h -> ok=%0b map=%0d data=0x%0h lat=%0d cs=%0d",
             id, we ? "insert" : "lookup", addr, ifc.rsp_ok, ifc.rsp_map, ifc.rsp_data,
             lat, cs_cnt);
  endtask

  logic grants [4];
  int   got, guard, seen_rsp;

  initial begin
    ifc.req_valid = '0;
    ifc.req_we    = '0;
    ifc.req_addr  = '0;
    ifc.req_data  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ram_cs", 64'(ram_cs), 64'd0);
    check_eq("rst_ram_we", 64'(ram_we), 64'd0);
    check_eq("rst_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    check_eq("rst_rsp_ok", 64'(ifc.rsp_ok), 64'd0);
    check_eq("rst_rsp_map", 64'(ifc.rsp_map), 64'd0);
    check_eq("rst_rsp_data", ifc.rsp_data, 64'd0);
    rst_n = 1'b1;

    // Literal lookup
    run_op(0, 1'b0, 12'h041, '0);
    check_eq("lk41_data", ifc.rsp_data, 64'h41);
    check_eq("lk41_map", 64'(ifc.rsp_map), 64'h41);
    check_eq("lk41_ok", 64'(ifc.rsp_ok), 64'd1);
    check_eq("lk41_cs", 64'(cs_cnt), 64'd2);

    // New entry gets code 256, then reads back
    run_op(1, 1'b1, 12'h300, 64'hABCD);
    check_eq("ins300_ok", 64'(ifc.rsp_ok), 64'd1);
    check_eq("ins300_map", 64'(ifc.rsp_map), 64'd256);
    check_eq("ins300_cs", 64'(cs_cnt), 64'd1);
    check_eq("ins300_full", 64'(ifc.dict_full), 64'd0);
    run_op(0, 1'b0, 12'h300, '0);
    check_eq("lk300_data", ifc.rsp_data, 64'hABCD);
    check_eq("lk300_map", 64'(ifc.rsp_map), 64'd256);
    check_eq("lk300_ok", 64'(ifc.rsp_ok), 64'd1);

    // Duplicate insert is refused by the RAM
    run_op(1, 1'b1, 12'h300, 64'h1234);
    check_eq("dup_ok", 64'(ifc.rsp_ok), 64'd0);
    check_eq("dup_map", 64'(ifc.rsp_map), 64'd0);
    check_eq("dup_cnt", 64'(ram_counter_out), 64'd257);

    // Both requesters contend for four operations
    @(negedge clk);
    ifc.req_we      = 2'b00;
    ifc.req_addr[0] = 12'h010;
    ifc.req_addr[1] = 12'h020;
    ifc.req_valid   = 2'b11;
    got   = 0;
    guard = 0;
    while (got < 4 && guard < 40) begin
      #1;
      if (ifc.req_ready != 2'b00) begin
        grants[got] = ifc.req_ready[1];
        got++;
      end
      @(negedge clk);
      guard++;
    end
    ifc.req_valid = 2'b00;
    check_eq("rr_count", 64'(got), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("rr_grant%0d", k), 64'(grants[k]), 64'(k % 2));
    end
    $display("[TB] round-robin grants %0d %0d %0d %0d", grants[0], grants[1], grants[2], grants[3]);
    repeat (4) @(negedge clk);

    // Last code, then a full dictionary
    load_val = 12'd4095;
    load_cnt = 1'b1;
    @(negedge clk);
    load_cnt = 1'b0;
    check_eq("pre_full", 64'(ifc.dict_full), 64'd0);
    run_op(0, 1'b1, 12'h500, 64'h55);
    check_eq("last_ok", 64'(ifc.rsp_ok), 64'd1);
    check_eq("last_map", 64'(ifc.rsp_map), 64'd4095);
    check_eq("last_full", 64'(ifc.dict_full), 64'd1);
    run_op(1, 1'b1, 12'h501, 64'h66);
    check_eq("full_ok", 64'(ifc.rsp_ok), 64'd0);
    check_eq("full_map", 64'(ifc.rsp_map), 64'd0);
    check_eq("full_cs", 64'(cs_cnt), 64'd0);

    // Reset while a lookup is in CAPTURE
    @(negedge clk);
    ifc.req_we[0]    = 1'b0;
    ifc.req_addr[0]  = 12'h041;
    ifc.req_valid[0] = 1'b1;
    #1;
    check_eq("pre_rst_grant", 64'(ifc.req_ready), 64'd1);
    @(negedge clk);
    ifc.req_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("cap_cs", 64'(ram_cs), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_cs", 64'(ram_cs), 64'd0);
    check_eq("arst_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    check_eq("arst_rsp_data", ifc.rsp_data, 64'd0);
    check_eq("arst_rsp_ok", 64'(ifc.rsp_ok), 64'd0);
    seen_rsp = 0;
    repeat (3) begin
      @(negedge clk);
      seen_rsp += int'(ifc.rsp_valid != 2'b00);
    end
    rst_n = 1'b1;
    ifc.req_valid = 2'b11;
    #1;
    check_eq("post_rst_grant", 64'(ifc.req_ready), 64'd1);
    @(negedge clk);
    ifc.req_valid = 2'b00;
    repeat (4) begin
      @(negedge clk);
      seen_rsp += int'(ifc.rsp_valid[1]);
    end
    check_eq("dropped_rsp", 64'(seen_rsp), 64'd0);
    $display("[TB] reset during CAPTURE: stray responses=%0d", seen_rsp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
